crc32_core: RTL and testbench
=============================

Name: crc32_core

Overview:
- MMIO peripheral that computes a reflected CRC-32 (IEEE 802.3, poly 0xEDB88320) over words and bytes the CPU writes to it.
- Sits directly downstream of the top-level CPU memory decoder, on a new MMIO core sub-prefix, with the same cs/we/address/write_data/read_data/ready slave interface as the other cores.
- Firmware and apps use it for integrity checks on loaded images without a software CRC loop.

Parameters:
- CORE_VERSION, 32'h00000001, value returned by the VERSION register.

Ports:
- clk  input  1  system clock; the only clock.
- reset_n  input  1  reset; synchronous, active-low.
- cs  input  1  chip select; high for exactly one cycle per CPU access.
- we  input  1  write enable; qualifies cs.
- address  input  8  word address within the core.
- write_data  input  32  write data.
- read_data  output  32  read data; combinational from registers, valid in the cs cycle.
- ready  output  1  access done; combinational, equals cs.

Behaviour:
- Register map (word address):
  - 0x00 NAME0, RO, 0x63726333 ("crc3").
  - 0x01 NAME1, RO, 0x32202020 ("2   ").
  - 0x02 VERSION, RO, CORE_VERSION.
  - 0x08 CTRL, WO: bit0=1 starts init.
  - 0x09 STATUS, RO: bit0 idle, bit1 error.
  - 0x10 DATA_WORD, WO: queues 4 bytes.
  - 0x11 DATA_BYTE, WO: queues write_data[7:0].
  - 0x20 RESULT, RO: ~crc_reg.
  - Other addresses read 0x00000000; writes to them are ignored.
  - Writes to RO registers are ignored. Reads have no side effects.
- Reset values: crc_reg=0xFFFFFFFF, shift_reg=0, byte_cnt=0, error=0, FSM=IDLE. RESULT reads 0x00000000 after reset.
- ready=cs in every cycle. Zero wait states; no access stalls.
- FSM states:
  - IDLE: idle=1.
  - BUSY: idle=0.
- Write DATA_WORD in IDLE:
  - Latch shift_reg=write_data and byte_cnt=4, then go to BUSY.
  - Each BUSY cycle processes shift_reg[7:0] into crc_reg, then shift_reg >>= 8 and byte_cnt -= 1.
  - Byte order is little-endian: write_data[7:0] first.
  - When byte_cnt reaches 0, return to IDLE.
  - Total: 4 BUSY cycles; STATUS.idle reads 1 in the 5th cycle after the write cycle.
- Write DATA_BYTE in IDLE: same, with byte_cnt=1. BUSY for 1 cycle.
- Byte step is 8 unrolled bit iterations in one cycle: c = (c>>1) ^ (0xEDB88320 & {32{c[0]^d[i]}}), i=0..7, LSB first.
- DATA write while BUSY: ignored, set error=1; crc_reg and the current operation are unaffected.
- CTRL bit0 write:
  - Has priority over everything else, in any state.
  - Sets crc_reg=0xFFFFFFFF, byte_cnt=0, error=0, FSM=IDLE.
  - Aborts any in-flight operation; takes effect in the next cycle.
- CTRL write with bit0=0: no effect.
- error is sticky; only init or reset clears it.
- RESULT read while BUSY returns ~crc_reg of the partial state; software polls STATUS.idle first.
- Reset asserted mid-operation: all state returns to reset values on the next clk edge; no partial byte is committed.
- No wrap limit on message length; crc_reg simply chains across writes.

Test Plan:
- Reset, read 0x00/0x01/0x02 -> 0x63726333, 0x32202020, 0x00000001; STATUS=0x1; RESULT=0x00000000; ready high only in cs cycles.
- Init, DATA_WORD 0x34333231, poll, DATA_WORD 0x38373635, poll, DATA_BYTE 0x39, poll -> RESULT=0xCBF43926 ("123456789"). STATUS.idle=0 for exactly 4 cycles after each word write and 1 cycle after the byte write.
- Init, DATA_BYTE 0x00 -> RESULT=0xD202EF8D. Init with no data -> RESULT=0x00000000.
- Init, DATA_WORD 0x34333231, then DATA_BYTE 0xFF on the next cycle (BUSY) -> STATUS=0x2 while busy and 0x3 when done; RESULT=CRC of "1234"=0x9BE3E0A3 (the byte is dropped). A following init -> STATUS=0x1.
- DATA_WORD then init 2 cycles later -> STATUS=0x1 on the next cycle; RESULT=0x00000000. Reset asserted mid-word -> same values.
- Write to NAME0 and to address 0x55; read 0x55 -> NAME0 unchanged, read returns 0x00000000, no state change.

Source files
------------

// File: rtl/crc32_core_if.sv
// CPU-side MMIO slave bus for crc32_core.
// Single-cycle cs/we access, read data and ready returned combinationally.
interface crc32_core_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output cs, we, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  cs, we, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/crc32_core.sv
// Reflected CRC-32 (IEEE 802.3) MMIO core.
// Bytes are folded into the CRC one per cycle, LSB first.
module crc32_core #(
  parameter logic [31:0] CORE_VERSION = 32'h00000001
) (
  input  logic        clk,
  input  logic        reset_n,
  crc32_core_if.slave bus
);

  localparam logic [31:0] POLY  = 32'hEDB88320;
  localparam logic [31:0] NAME0 = 32'h63726333;
  localparam logic [31:0] NAME1 = 32'h32202020;

  localparam logic [7:0] A_NAME0   = 8'h00;
  localparam logic [7:0] A_NAME1   = 8'h01;
  localparam logic [7:0] A_VERSION = 8'h02;
  localparam logic [7:0] A_CTRL    = 8'h08;
  localparam logic [7:0] A_STATUS  = 8'h09;
  localparam logic [7:0] A_WORD    = 8'h10;
  localparam logic [7:0] A_BYTE    = 8'h11;
  localparam logic [7:0] A_RESULT  = 8'h20;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state;
  logic [31:0] crc_reg;
  logic [31:0] shift_reg;
  logic [2:0]  byte_cnt;
  logic        error;

  logic wr;
  logic init;
  logic wr_word;
  logic wr_byte;
  logic data_wr;
  logic idle;

  assign wr      = bus.cs & bus.we;
  assign init    = wr & (bus.address == A_CTRL) & bus.write_data[0];
  assign wr_word = wr & (bus.address == A_WORD);
  assign wr_byte = wr & (bus.address == A_BYTE);
  assign data_wr = wr_word | wr_byte;
  assign idle    = (state == IDLE);

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (POLY & {32{r[0] ^ d[i]}});
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      crc_reg   <= 32'hFFFFFFFF;
      shift_reg <= '0;
      byte_cnt  <= '0;
      error     <= 1'b0;
    end else if (init) begin
      state    <= IDLE;
      crc_reg  <= 32'hFFFFFFFF;
      byte_cnt <= '0;
      error    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_wr) begin
            shift_reg <= bus.write_data;
            byte_cnt  <= wr_word ? 3'd4 : 3'd1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          crc_reg   <= crc_byte(crc_reg, shift_reg[7:0]);
          shift_reg <= shift_reg >> 8;
          byte_cnt  <= byte_cnt - 3'd1;
          if (byte_cnt == 3'd1) state <= IDLE;
          // a second data write cannot be queued; flag it and drop it
          if (data_wr) error <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.read_data = '0;
    unique case (1'b1)
      (bus.address == A_NAME0):   bus.read_data = NAME0;
      (bus.address == A_NAME1):   bus.read_data = NAME1;
      (bus.address == A_VERSION): bus.read_data = CORE_VERSION;
      (bus.address == A_STATUS):  bus.read_data = {30'b0, error, idle};
      (bus.address == A_RESULT):  bus.read_data = ~crc_reg;
      default:                    bus.read_data = '0;
    endcase
  end

  assign bus.ready = bus.cs;

endmodule

// File: tb/tb_crc32_core.sv
// Bench for crc32_core: fixed vectors plus random messages
// checked against a table-driven CRC-32 model.
module tb_crc32_core;

  logic clk = 1'b0;
  logic reset_n;
  int   errs = 0;
  int   checks = 0;

  logic [31:0] tbl [256];
  logic [7:0]  msg [$];

  crc32_core_if bus ();

  crc32_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.cs = 1'b1;
    bus.we = 1'b1;
    bus.address = a;
    bus.write_data = d;
    @(negedge clk);
    bus.cs = 1'b0;
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.cs = 1'b1;
    bus.we = 1'b0;
    bus.address = a;
    #1;
    d = bus.read_data;
    check("ready_cs", {31'b0, bus.ready}, 32'd1);
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic idle_cyc();
    #1;
    check("ready_nocs", {31'b0, bus.ready}, 32'd0);
    @(negedge clk);
  endtask

  task automatic rd_chk(
    input string       tag,
    input logic [7:0]  a,
    input logic [31:0] exp
  );
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_idle(output int busy, output logic [31:0] st);
    busy = 0;
    st = '0;
    for (int i = 0; i < 12; i++) begin
      rd(8'h09, st);
      if (st[0]) return;
      busy++;
    end
    check("poll_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] ref_result();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (msg[i]) c = tbl[(c ^ {24'b0, msg[i]}) & 32'hFF] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic push_data(input bit is_word, input logic [31:0] d);
    if (is_word) begin
      for (int i = 0; i < 4; i++) msg.push_back(d[8*i +: 8]);
    end else begin
      msg.push_back(d[7:0]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] st;
    logic [31:0] d;
    bit          is_word;
    bit          inj;
    bit          err_exp;
    int          items;

    for (int k = 0; k < 256; k++) begin
      logic [31:0] c;
      c = k;
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[k] = c;
    end

    bus.cs = 1'b0;
    bus.we = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    idle_cyc();
    rd_chk("name0", 8'h00, 32'h63726333);
    rd_chk("name1", 8'h01, 32'h32202020);
    rd_chk("version", 8'h02, 32'h00000001);
    rd_chk("status_rst", 8'h09, 32'h1);
    rd_chk("result_rst", 8'h20, 32'h0);

    wr(8'h08, 32'h1);
    wr(8'h10, 32'h34333231);
    wait_idle(n, st);
    check("busy_w1", n, 4);
    wr(8'h10, 32'h38373635);
    wait_idle(n, st);
    check("busy_w2", n, 4);
    wr(8'h11, 32'hABCDEF39);
    wait_idle(n, st);
    check("busy_b", n, 1);
    rd_chk("crc_123456789", 8'h20, 32'hCBF43926);
    wr(8'h08, 32'hFFFFFFFE);
    rd_chk("ctrl_bit0_low", 8'h20, 32'hCBF43926);

    wr(8'h08, 32'h1);
    wr(8'h11, 32'h0);
    wait_idle(n, st);
    rd_chk("crc_00", 8'h20, 32'hD202EF8D);
    wr(8'h08, 32'h1);
    rd_chk("crc_empty", 8'h20, 32'h0);

    wr(8'h08, 32'h1);
    wr(8'h10, 32'h34333231);
    wr(8'h11, 32'hFF);
    rd_chk("status_err_busy", 8'h09, 32'h2);
    wait_idle(n, st);
    check("status_err_done", st, 32'h3);
    rd_chk("crc_1234", 8'h20, 32'h9BE3E0A3);
    wr(8'h08, 32'h1);
    rd_chk("status_err_clr", 8'h09, 32'h1);

    wr(8'h10, 32'h34333231);
    idle_cyc();
    wr(8'h08, 32'h1);
    rd_chk("abort_status", 8'h09, 32'h1);
    rd_chk("abort_result", 8'h20, 32'h0);

    wr(8'h10, 32'h34333231);
    idle_cyc();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("rst_mid_status", 8'h09, 32'h1);
    rd_chk("rst_mid_result", 8'h20, 32'h0);

    wr(8'h11, 32'h31);
    wait_idle(n, st);
    wr(8'h00, 32'hDEADBEEF);
    rd_chk("name0_ro", 8'h00, 32'h63726333);
    wr(8'h55, 32'h12345678);
    rd_chk("unmapped", 8'h55, 32'h0);
    rd_chk("unmapped_status", 8'h09, 32'h1);
    rd_chk("unmapped_result", 8'h20, 32'h83DCEFB7);

    for (int t = 0; t < 25; t++) begin
      wr(8'h08, 32'h1);
      msg.delete();
      err_exp = 1'b0;
      items = $urandom_range(1, 5);
      for (int j = 0; j < items; j++) begin
        is_word = $urandom_range(0, 1) == 1;
        d = $urandom;
        wr(is_word ? 8'h10 : 8'h11, d);
        push_data(is_word, d);
        inj = 1'b0;
        if (is_word && $urandom_range(0, 3) == 0) begin
          wr($urandom_range(0, 1) == 1 ? 8'h10 : 8'h11, $urandom);
          inj = 1'b1;
          err_exp = 1'b1;
        end
        wait_idle(n, st);
        check("rand_busy", n + int'(inj), is_word ? 4 : 1);
      end
      rd_chk("rand_result", 8'h20, ref_result());
      rd_chk("rand_status", 8'h09, {30'b0, err_exp, 1'b1});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
